// File: rtl/ysyx_22050019_ifq.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular FIFO of {pc, inst}
// with valid/ready toward decode, a full-stall toward fetch and a flush on redirect.
module ysyx_22050019_ifq #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ifu_ok_i,
   input  logic [63:0]                inst_addr_i,
   input  logic [31:0]                inst_i,
   input  logic                       flush_i,
   output logic                       pc_stall_o,
   output logic                       id_valid_o,
   input  logic                       id_ready_i,
   output logic [63:0]                id_pc_o,
   output logic [31:0]                id_inst_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       ovf_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [63:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];
   logic [AW-1:0] rp_q, rp_d;
   logic [AW-1:0] wp_q, wp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          full, empty, push, pop;

   always_comb begin
      full  = (cnt_q == FULL_CNT);
      empty = (cnt_q == '0);
      push  = ifu_ok_i & ~full & ~flush_i;
      pop   = ~empty & id_ready_i & ~flush_i;
      rp_d  = rp_q;
      wp_d  = wp_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (flush_i) begin
         rp_d  = '0;
         wp_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) wp_d = wp_q + AW'(1);
         if (pop)  rp_d = rp_q + AW'(1);
         if (push && !pop)      cnt_d = cnt_q + CW'(1);
         else if (pop && !push) cnt_d = cnt_q - CW'(1);
         // A fetch that ignores the stall loses its instruction; remember it for debug.
         if (ifu_ok_i && full)  ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rp_q  <= '0;
         wp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         rp_q  <= rp_d;
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wp_q]   <= inst_addr_i;
         inst_mem[wp_q] <= inst_i;
      end
   end

   assign pc_stall_o = full;
   assign id_valid_o = ~empty;
   assign id_pc_o    = empty ? 64'h0 : pc_mem[rp_q];
   assign id_inst_o  = empty ? NOP_INST : inst_mem[rp_q];
   assign count_o    = cnt_q;
   assign ovf_o      = ovf_q;
endmodule

// File: doc/ysyx_22050019_ifq.md
# ysyx_22050019_ifq

Instruction queue between the fetch stage and the decode stage. Captures each fetched instruction and its PC on the fetch-complete pulse and holds them in a DEPTH-entry circular FIFO. Presents the oldest entry to decode with a valid/ready handshake. Back-pressures fetch through its stall input and discards all in-flight entries on a redirect (flush).

## Interface
- `DEPTH`, default 4: number of entries. Must be a power of two, ≥ 2.
- `NOP_INST`, default 32'h00000013: instruction driven on `id_inst_o` when the queue is empty.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ifu_ok_i`  in  1  fetch-complete pulse from fetch; one instruction per high cycle.
- `inst_addr_i`  in  64  PC of the fetched instruction; valid while `ifu_ok_i` is high.
- `inst_i`  in  32  fetched instruction; valid while `ifu_ok_i` is high.
- `flush_i`  in  1  redirect (taken jump or branch); empties the queue.
- `pc_stall_o`  out  1  high when the queue is full; drives fetch's stall input.
- `id_valid_o`  out  1  head entry is valid.
- `id_ready_i`  in  1  decode accepts the head entry this cycle.
- `id_pc_o`  out  64  PC of the head entry.
- `id_inst_o`  out  32  instruction of the head entry.
- `count_o`  out  $clog2(DEPTH)+1  number of occupied entries.
- `ovf_o`  out  1  sticky error flag: a push was attempted while full.

## Operation
State:
- Storage arrays `pc_mem[DEPTH]` and `inst_mem[DEPTH]`.
- Read pointer `rp` and write pointer `wp`, each $clog2(DEPTH) bits; both wrap modulo DEPTH.
- Occupancy counter `cnt`, 0..DEPTH.
- Sticky register `ovf`.

Events in a cycle:
- Flag definitions:
  - `full` = (cnt == DEPTH)
  - `empty` = (cnt == 0)
  - `push` = `ifu_ok_i` & ~`full` & ~`flush_i`
  - `pop` = `id_valid_o` & `id_ready_i` & ~`flush_i`
- On `push`: write `inst_addr_i` to `pc_mem[wp]` and `inst_i` to `inst_mem[wp]`; `wp` ← `wp`+1.
- On `pop`: `rp` ← `rp`+1.
- Counter update:
  - push only: `cnt`+1.
  - pop only: `cnt`−1.
  - push and pop together: `cnt` unchanged. This is legal only when not full, because push is blocked when full; the pop still occurs.
- On `flush_i`: `rp` ← 0, `wp` ← 0, `cnt` ← 0. Any same-cycle `ifu_ok_i` or `id_ready_i` is ignored. Storage contents are not cleared.
- `ifu_ok_i` while `full` and no flush: the instruction is dropped, nothing changes, and `ovf` ← 1. `ovf` clears only on reset. Fetch must never do this, because its pc_wen is gated by the stall.

Outputs, all decoded from registered state with no input-to-output combinational path:
- `pc_stall_o` = `full`.
- `id_valid_o` = ~`empty`.
- `id_pc_o` = `pc_mem[rp]` when not empty, else 64'h0.
- `id_inst_o` = `inst_mem[rp]` when not empty, else `NOP_INST`.
- `count_o` = `cnt`.
- `ovf_o` = `ovf`.

Reset (asynchronous, `rst_n` low):
- `rp`, `wp`, `cnt` and `ovf` go to 0 immediately.
- Outputs therefore read: `pc_stall_o`=0, `id_valid_o`=0, `id_pc_o`=0, `id_inst_o`=`NOP_INST`, `count_o`=0, `ovf_o`=0.
- Storage arrays are not reset.
- Reset asserted mid-operation discards all entries with no partial state retained.

## Timing
- Push-to-visible latency is 1 cycle. An entry pushed at edge k appears on `id_*` after edge k; there is no same-cycle bypass.
- Pop takes effect at the edge where `id_valid_o`&`id_ready_i` is high. The next entry, if any, is presented after that edge.
- Sustained throughput is 1 push and 1 pop per cycle while 0 < `cnt` < DEPTH.
- `pc_stall_o` rises in the cycle after the push that fills the queue. It falls in the cycle after the first pop from full.
- Flush takes 1 cycle. After the flush edge, `id_valid_o`=0 and `pc_stall_o`=0. A push in the following cycle is accepted normally.
- Pointer wrap: after DEPTH pushes, `wp` returns to 0. FIFO order is preserved across the wrap.
- `id_ready_i` while empty has no effect.

## Test plan
- Reset, then push PC 0x80000000 / inst 0x00100093 at cycle 1 with `id_ready_i`=0. After the edge: `id_valid_o`=1, `id_pc_o`=0x80000000, `id_inst_o`=0x00100093, `count_o`=1.
- Push 4 entries (PC 0x80000000..0x8000000C) with `id_ready_i`=0. Then `pc_stall_o`=1 and `count_o`=4. A 5th `ifu_ok_i` is dropped and `ovf_o`=1. Next, raise `id_ready_i`: the 4 pops return the PCs in order, and `pc_stall_o` falls after the first pop.
- Continuous stream of 10 pushes with `id_ready_i`=1 every cycle. `count_o` stays at 1, every PC comes out in order with 1-cycle latency, and the pointers wrap twice with no loss.
- Fill 3 entries, then assert `flush_i` together with `ifu_ok_i` (PC 0x80000100) and `id_ready_i`. After the edge: `count_o`=0, `id_valid_o`=0, `id_inst_o`=0x00000013. Push PC 0x80000200 next cycle; it appears alone at the head.
- With `count_o`=2, push and pop in the same cycle. `count_o` stays 2, the head advances to the second entry, and the new entry lands at the tail.
- Drop `rst_n` asynchronously mid-stream, between edges, with `count_o`=3. All outputs return to their reset values immediately, without waiting for a clock edge.
